// File: rtl/uart_tx_wb_if.sv
// Wishbone slave bus bundle for uart_tx_wb.
// Carries the address, data, strobe and acknowledge signals.
interface uart_tx_wb_if;
  logic [31:0] addr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        we_i;
  logic [3:0]  sel_i;
  logic        cyc_i;
  logic        stb_i;
  logic        ack_o;

  modport slave (
    input  addr_i, dat_i, we_i,
    input  sel_i, cyc_i, stb_i,
    output dat_o, ack_o
  );

  modport master (
    output addr_i, dat_i, we_i,
    output sel_i, cyc_i, stb_i,
    input  dat_o, ack_o
  );
endinterface

// File: rtl/uart_tx_wb.sv
// Wishbone UART transmitter: 4-byte buffer, 8N1 frames.
// Define UART_TX_PARITY_EN for 8E1 frames (even parity).
module uart_tx_wb #(
  parameter logic [31:0] ADDR_CTRL   = 32'h3,
  parameter logic [31:0] ADDR_BAUD   = 32'h4,
  parameter logic [31:0] ADDR_STATUS = 32'h5,
  parameter logic [31:0] ADDR_TXBUF  = 32'h7,
  parameter logic [31:0] BAUD_RESET  = 32'h0096FEB5
) (
  input  logic        clk_i,
  input  logic        ext_rst_i,
  uart_tx_wb_if.slave wb,
  output logic        tx_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] baud_q, baud_d;
  logic [31:0] txbuf_q, txbuf_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] dat_q, dat_d;
  logic [1:0]  len_q, len_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  bit_q, bit_d;
  logic        ready_q, ready_d;
  logic        ack_q, ack_d;

  logic [31:0] rdata;
  logic [31:0] acc_sum;
  logic        wr, rd, idle, start;
  logic        tick, done, tx;
  logic        hit_ctrl, hit_baud;
  logic        hit_status, hit_txbuf;
  logic        unused_cyc;

  assign unused_cyc = wb.cyc_i;

  assign wr = wb.stb_i & wb.we_i;
  assign rd = wb.stb_i & ~wb.we_i;

  assign hit_ctrl   = (wb.addr_i == ADDR_CTRL);
  assign hit_baud   = (wb.addr_i == ADDR_BAUD);
  assign hit_status = (wb.addr_i == ADDR_STATUS);
  assign hit_txbuf  = (wb.addr_i == ADDR_TXBUF);

  assign idle  = (state_q == S_IDLE);
  assign start = wr & hit_ctrl & wb.dat_i[7] & idle;

  // Baud tick is the carry out of the phase add
  assign {tick, acc_sum} =
    {1'b0, acc_q} + {1'b0, baud_q};

`ifdef UART_TX_PARITY_EN
  logic [7:0] cur_byte;
  assign cur_byte = shift_q[{idx_q, 3'b000} +: 8];
`endif

  // Read data mux for the addressed register
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit_ctrl:   rdata = {30'b0, len_q};
      hit_baud:   rdata = baud_q;
      hit_status: rdata = {26'b0, ~idle, ready_q, 4'b0};
      hit_txbuf:  rdata = txbuf_q;
      default:    rdata = '0;
    endcase
  end

  // Bus-visible registers, accumulator and shift copy
  always_comb begin
    baud_d  = baud_q;
    txbuf_d = txbuf_q;
    len_d   = len_q;
    ready_d = ready_q;
    shift_d = shift_q;
    ack_d   = wb.stb_i;
    dat_d   = dat_q;
    acc_d   = idle ? '0 : acc_sum;
    if (rd) dat_d = rdata;
    if (wr & hit_baud) baud_d = wb.dat_i;
    for (int n = 0; n < 4; n++) begin
      if (wr & hit_txbuf & wb.sel_i[n])
        txbuf_d[8*n +: 8] = wb.dat_i[8*n +: 8];
    end
    if (wr & hit_ctrl & idle)
      len_d = wb.dat_i[1:0];
    if (start) shift_d = txbuf_q;
    if ((wr & hit_status) | start)
      ready_d = 1'b0;
    if (done) ready_d = 1'b1;
  end

  // Frame sequencer: next state and line level
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    done    = 1'b0;
    tx      = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_START;
          idx_d   = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (tick) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        tx = shift_q[{idx_q, bit_q}];
        if (tick) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx = ^cur_byte;
        if (tick) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (idx_q < len_q) begin
            idx_d   = idx_q + 2'd1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
            done    = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with async active-low reset
  always_ff @(posedge clk_i or negedge ext_rst_i) begin
    if (!ext_rst_i) begin
      state_q <= S_IDLE;
      baud_q  <= BAUD_RESET;
      txbuf_q <= '0;
      shift_q <= '0;
      acc_q   <= '0;
      dat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      bit_q   <= '0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      txbuf_q <= txbuf_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      dat_q   <= dat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
    end
  end

  assign wb.ack_o = ack_q;
  assign wb.dat_o = dat_q;
  assign tx_o     = tx;
  assign busy_o   = ~idle;

endmodule

// File: tb/tb_uart_tx_wb.sv
// Testbench for uart_tx_wb: scoreboard of per-clock
// line levels built from a bit-stream reference model.
module tb_uart_tx_wb;

  localparam logic [31:0] BAUD_RST = 32'h0096FEB5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx, busy;

  uart_tx_wb_if bus ();

  uart_tx_wb dut (
    .clk_i     (clk),
    .ext_rst_i (rst_n),
    .wb        (bus),
    .tx_o      (tx),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // expected {busy, tx} per clock while a frame runs
  logic [1:0] q[$];

  logic [31:0] m_baud = BAUD_RST;
  logic [31:0] m_txbuf = '0;
  logic [1:0]  m_len = '0;
  bit          m_has = 1'b0;
  longint      m_start = 0;
  longint      m_clear = 0;
  longint      m_idle_at = 0;
  logic [31:0] last_rd = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h",
               nm, act, exp);
    end
  endtask

  // Monitor: compare line and busy every clock
  always @(negedge clk) begin
    logic [1:0] e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("mon_busy", 32'(busy), 32'(e[1]));
      chk("mon_tx", 32'(tx), 32'(e[0]));
    end else begin
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_tx", 32'(tx), 32'd1);
    end
  end

  // Frame bits as a flat list; bit i ends at the
  // i+1'th accumulator carry after the start edge.
  function automatic void start_frame(input longint m);
    logic b[$];
    logic [7:0] by;
    longint t;
    int ix;
    for (int k = 0; k <= int'(m_len); k++) begin
      by = m_txbuf[8*k +: 8];
      b.push_back(1'b0);
      for (int i = 0; i < 8; i++) b.push_back(by[i]);
`ifdef UART_TX_PARITY_EN
      b.push_back(^by);
`endif
      b.push_back(1'b1);
    end
    m_has = 1'b1;
    m_start = m;
    m_clear = m;
    if (m_baud == 0) begin
      for (int i = 0; i < 20; i++) q.push_back(2'b10);
      m_idle_at = 64'h3FFF_FFFF_FFFF_FFFF;
    end else begin
      t = 0;
      ix = 0;
      while (ix < b.size()) begin
        q.push_back({1'b1, b[ix]});
        t++;
        ix = int'((t * longint'(m_baud)) >> 32);
      end
      m_idle_at = m + t;
    end
  endfunction

  function automatic logic [31:0] model_read(
      input logic [31:0] a, input longint r);
    logic bz, rdy;
    bz  = m_has && (r - 1 >= m_start)
               && (r - 1 < m_idle_at);
    rdy = m_has && (m_idle_at <= r - 1)
               && (m_idle_at >= m_clear);
    case (a)
      32'h3: return {30'b0, m_len};
      32'h4: return m_baud;
      32'h5: return {26'b0, bz, rdy, 4'b0};
      32'h7: return m_txbuf;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_write(
      input logic [31:0] a, input logic [31:0] d,
      input logic [3:0] s, input longint m);
    case (a)
      32'h3: begin
        if (!m_has || (m - 1 >= m_idle_at)) begin
          m_len = d[1:0];
          if (d[7]) start_frame(m);
        end
      end
      32'h4: m_baud = d;
      32'h5: m_clear = m;
      32'h7: begin
        for (int n = 0; n < 4; n++)
          if (s[n]) m_txbuf[8*n +: 8] = d[8*n +: 8];
      end
      default: ;
    endcase
  endfunction

  // One bus access; entered and left 2 ns after an edge
  task automatic access(input logic [31:0] a,
                        input logic we,
                        input logic [31:0] d,
                        input logic [3:0] s);
    logic [31:0] e;
    bus.addr_i = a;
    bus.we_i   = we;
    bus.dat_i  = d;
    bus.sel_i  = s;
    bus.cyc_i  = 1'b1;
    bus.stb_i  = 1'b1;
    @(posedge clk);
    #1;
    chk("ack", 32'(bus.ack_o), 32'd1);
    if (!we) begin
      e = model_read(a, cyc);
      chk($sformatf("rd_%0h", a), bus.dat_o, e);
      last_rd = e;
    end else begin
      chk("dat_hold", bus.dat_o, last_rd);
      model_write(a, d, s, cyc);
    end
    #1;
    bus.stb_i = 1'b0;
    bus.cyc_i = 1'b0;
    bus.we_i  = 1'b0;
  endtask

  task automatic idle1();
    bus.stb_i = 1'b0;
    @(posedge clk);
    #1;
    chk("ack_idle", 32'(bus.ack_o), 32'd0);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cyc < m_idle_at && n < 20000) begin
      idle1();
      n++;
    end
    if (cyc < m_idle_at) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: busy after %0d clocks", n);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tx", 32'(tx), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ack", 32'(bus.ack_o), 32'd0);
    chk("arst_dat", bus.dat_o, 32'd0);
    q.delete();
    m_has = 1'b0;
    m_baud = BAUD_RST;
    m_txbuf = '0;
    m_len = '0;
    last_rd = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] b, d;
    logic [1:0]  l;
    bus.addr_i = '0;
    bus.dat_i  = '0;
    bus.we_i   = 1'b0;
    bus.sel_i  = '0;
    bus.cyc_i  = 1'b0;
    bus.stb_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(bus.ack_o), 32'd0);
    chk("rst_dat", bus.dat_o, 32'd0);
    #1;
    rst_n = 1'b1;

    access(32'h4, 1'b0, 0, 4'h0);
    access(32'h5, 1'b0, 0, 4'h0);
    access(32'h3, 1'b0, 0, 4'h0);
    access(32'h7, 1'b0, 0, 4'h0);
    access(32'h6, 1'b1, 32'hDEADBEEF, 4'hF);
    access(32'h6, 1'b0, 0, 4'h0);
    access(32'h104, 1'b0, 0, 4'h0);

    // single 0x55 frame, 4 clocks per bit
    access(32'h4, 1'b1, 32'h40000000, 4'hF);
    access(32'h7, 1'b1, 32'h00000055, 4'hF);
    access(32'h3, 1'b1, 32'h80, 4'h0);
    wait_idle();
    access(32'h5, 1'b0, 0, 4'h0);

    // four back-to-back frames; restart attempt mid-frame
    access(32'h7, 1'b1, 32'h34333231, 4'hF);
    access(32'h3, 1'b1, 32'h83, 4'h0);
    repeat (30) idle1();
    access(32'h3, 1'b1, 32'h80, 4'h0);
    access(32'h7, 1'b1, 32'h000000FF, 4'hF);
    wait_idle();
    access(32'h7, 1'b0, 0, 4'h0);
    access(32'h5, 1'b0, 0, 4'h0);
    access(32'h3, 1'b0, 0, 4'h0);

    // STATUS write on the edge READY sets
    access(32'h3, 1'b1, 32'h80, 4'h0);
    while (cyc < m_idle_at - 1) idle1();
    access(32'h5, 1'b1, 0, 4'h0);
    access(32'h5, 1'b0, 0, 4'h0);
    access(32'h5, 1'b1, 0, 4'h0);
    access(32'h5, 1'b0, 0, 4'h0);

    // reset in the middle of the data bits
    access(32'h7, 1'b1, 32'h00000055, 4'hF);
    access(32'h3, 1'b1, 32'h80, 4'h0);
    repeat (12) idle1();
    do_reset();
    access(32'h4, 1'b0, 0, 4'h0);
    access(32'h5, 1'b0, 0, 4'h0);
    access(32'h4, 1'b1, 32'h40000000, 4'hF);
    access(32'h7, 1'b1, 32'h00000055, 4'hF);
    access(32'h3, 1'b1, 32'h80, 4'h0);
    wait_idle();
    access(32'h7, 1'b1, 32'h00000007, 4'hF);
    access(32'h3, 1'b1, 32'h80, 4'h0);
    wait_idle();
    access(32'h5, 1'b0, 0, 4'h0);

    // randomized baud, buffer contents and length
    for (int it = 0; it < 10; it++) begin
      b = $urandom_range(32'h7FFFFFFF, 32'h08000000);
      d = $urandom;
      l = 2'($urandom_range(3, 0));
      access(32'h4, 1'b1, b, 4'hF);
      access(32'h7, 1'b1, d, 4'($urandom_range(15, 0)));
      access(32'h3, 1'b1, {24'b0, 1'b1, 5'b0, l}, 4'h0);
      repeat ($urandom_range(8, 0)) idle1();
      access(32'h5, 1'b0, 0, 4'h0);
      wait_idle();
      access(32'h5, 1'b0, 0, 4'h0);
      access(32'h3, 1'b0, 0, 4'h0);
      access(32'h7, 1'b0, 0, 4'h0);
    end

    // zero increment never ticks; leave via reset
    access(32'h4, 1'b1, 32'h0, 4'hF);
    access(32'h3, 1'b1, 32'h80, 4'h0);
    repeat (19) idle1();
    do_reset();
    repeat (3) idle1();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
